hpdcache_rr_arb_lock: RTL and testbench

- Round-robin arbiter with grant locking under back-pressure.
- Generates the one-hot select that drives the downstream one-hot-select data multiplexer, which gathers requester payloads onto a shared channel.
- Also provides a binary grant index and per-requester ready.
- Sits between N valid/ready requesters (e.g. core ports, refill/flush engines) and the single shared request channel.

---
 rtl/hpdcache_rr_arb_lock.sv | 128 ++++++++++++
 tb/tb_hpdcache_rr_arb_lock.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_rr_arb_lock.sv
// rtl/hpdcache_rr_arb_lock.sv - round-robin arbiter with grant locking under back-pressure
//
// Arbitrates NREQ valid/ready requesters onto one shared valid/ready channel.
// Produces a one-hot grant (mux select), its binary index and per-requester
// ready. A grant offered but not accepted is held (locked) until the transfer
// completes, so the downstream channel sees a stable payload.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   req_valid_i  [NREQ]       per-requester valid
//   req_ready_o  [NREQ]       per-requester ready (grant & out_ready_i)
//   gnt_o        [NREQ]       one-hot grant, zero when nothing is offered
//   gnt_idx_o    [NREQ_LOG2]  binary index of the grant, zero when gnt_o is zero
//   out_valid_o               shared channel valid
//   out_ready_i               shared channel ready
//
// Configuration macro:
//   HPDCACHE_RR_ARB_FIXED_PRIO_EN  when defined, the round-robin pointer is
//   removed and arbitration is fixed priority (lowest index wins); locking is
//   unchanged.

module hpdcache_rr_arb_lock #(
    parameter int unsigned NREQ      = 4,
    localparam int unsigned NREQ_LOG2 = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ_LOG2-1:0] gnt_idx_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam logic [NREQ_LOG2:0]   NREQ_EXT = (NREQ_LOG2 + 1)'(NREQ);
    localparam logic [NREQ_LOG2-1:0] LAST_IDX = NREQ_LOG2'(NREQ - 1);

    logic [NREQ_LOG2-1:0] ptr;
    logic                 lock_q;
    logic [NREQ_LOG2-1:0] lock_idx_q;

    // Free-running arbitration result (used when not locked)
    logic [NREQ-1:0]      free_gnt;
    logic [NREQ_LOG2-1:0] free_idx;
    logic                 free_found;
    logic [NREQ_LOG2:0]   scan_pos;

    logic transfer;
    logic stall;

    // Rotating priority scan starting at ptr. The candidate index is formed
    // one bit wider than the pointer so the wrap against NREQ is an explicit
    // compare, which is required for non-power-of-2 NREQ.
    always_comb begin
        free_gnt   = '0;
        free_idx   = '0;
        free_found = 1'b0;
        scan_pos   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_pos = {1'b0, ptr} + (NREQ_LOG2 + 1)'(k);
            if (scan_pos >= NREQ_EXT) begin
                scan_pos = scan_pos - NREQ_EXT;
            end
            if (!free_found && req_valid_i[scan_pos[NREQ_LOG2-1:0]]) begin
                free_found = 1'b1;
                free_idx   = scan_pos[NREQ_LOG2-1:0];
                free_gnt   = NREQ'(1) << scan_pos[NREQ_LOG2-1:0];
            end
        end
    end

    // While locked the grant stays on the locked requester even if it drops
    // its valid (protocol violation); out_valid_o then falls so nothing
    // transfers and the lock is released on the next edge.
    always_comb begin
        if (lock_q) begin
            gnt_o       = NREQ'(1) << lock_idx_q;
            gnt_idx_o   = lock_idx_q;
            out_valid_o = req_valid_i[lock_idx_q];
        end else begin
            gnt_o       = free_gnt;
            gnt_idx_o   = free_idx;
            out_valid_o = |req_valid_i;
        end
    end

    assign req_ready_o = gnt_o & {NREQ{out_ready_i}};

    assign transfer = out_valid_o & out_ready_i;
    assign stall    = out_valid_o & ~out_ready_i;

`ifdef HPDCACHE_RR_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [NREQ_LOG2-1:0] ptr_q;
    logic [NREQ_LOG2-1:0] ptr_next;

    // Next start index is the one just past the winner, wrapping at NREQ-1.
    assign ptr_next = (gnt_idx_o == LAST_IDX) ? '0 : gnt_idx_o + 1'b1;
    assign ptr      = ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (transfer) begin
            ptr_q <= ptr_next;
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (transfer) begin
            lock_q <= 1'b0;
        end else if (stall) begin
            lock_q     <= 1'b1;
            lock_idx_q <= gnt_idx_o;
        end else if (lock_q) begin
            // Locked requester withdrew its valid: release without moving ptr.
            lock_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hpdcache_rr_arb_lock.sv
// tb/tb_hpdcache_rr_arb_lock.sv - scoreboard bench for hpdcache_rr_arb_lock

module tb_hpdcache_rr_arb_lock;

    localparam int NREQ = 4;
    localparam int W    = 2;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [NREQ-1:0] req_valid_i = '0;
    logic [NREQ-1:0] req_ready_o;
    logic [NREQ-1:0] gnt_o;
    logic [W-1:0]    gnt_idx_o;
    logic            out_valid_o;
    logic            out_ready_i = 1'b0;

    always #5 clk = ~clk;

    hpdcache_rr_arb_lock #(.NREQ(NREQ)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .gnt_o       (gnt_o),
        .gnt_idx_o   (gnt_idx_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    typedef struct {
        int              cyc;
        logic [NREQ-1:0] gnt;
        int              idx;
        logic            val;
        logic [NREQ-1:0] rdy;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state, kept as plain integers
    int m_ptr   = 0;
    bit m_lock  = 0;
    int m_owner = 0;

    task automatic step(input logic [NREQ-1:0] v, input logic rdy, input logic rst);
        exp_t e;
        int   c;
        bit   hit;
        @(posedge clk);
        #1;
        rst_i       = rst;
        req_valid_i = v;
        out_ready_i = rdy;
        cyc++;

        e.cyc = cyc;
        if (m_lock) begin
            e.gnt = '0;
            e.gnt[m_owner] = 1'b1;
            e.idx = m_owner;
            e.val = v[m_owner];
        end else begin
            e.gnt = '0;
            e.idx = 0;
            e.val = (v != '0);
            hit   = 0;
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!hit && v[c]) begin
                    hit = 1;
                    e.idx = c;
                    e.gnt[c] = 1'b1;
                end
            end
        end
        e.rdy = rdy ? e.gnt : '0;
        exp_q.push_back(e);

        // State the DUT will hold after the coming rising edge
        if (rst) begin
            m_ptr = 0; m_lock = 0; m_owner = 0;
        end else if (e.val && rdy) begin
            m_ptr  = (e.idx + 1) % NREQ;
            m_lock = 0;
        end else if (e.val) begin
            m_lock  = 1;
            m_owner = e.idx;
        end else if (m_lock) begin
            m_lock = 0;
        end
`ifdef HPDCACHE_RR_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`endif
    endtask

    // Monitor: outputs are combinational, so each driven cycle is checked
    // at the falling edge, well away from the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (gnt_o !== e.gnt) begin
                    n_fail++;
                    $display("FAIL gnt cyc=%0d got=%b exp=%b", e.cyc, gnt_o, e.gnt);
                end
                n_cmp++;
                if (int'(gnt_idx_o) != e.idx || $isunknown(gnt_idx_o)) begin
                    n_fail++;
                    $display("FAIL gnt_idx cyc=%0d got=%0d exp=%0d", e.cyc, gnt_idx_o, e.idx);
                end
                n_cmp++;
                if (out_valid_o !== e.val) begin
                    n_fail++;
                    $display("FAIL out_valid cyc=%0d got=%b exp=%b", e.cyc, out_valid_o, e.val);
                end
                n_cmp++;
                if (req_ready_o !== e.rdy) begin
                    n_fail++;
                    $display("FAIL req_ready cyc=%0d got=%b exp=%b", e.cyc, req_ready_o, e.rdy);
                end
            end
        end
    end

    initial begin
        logic [NREQ-1:0] rv;
        logic            rr;
        logic            rs;
        int              guard;

        // Reset, then idle after reset
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b1, 1'b0);

        // Rotation: all requesting, always ready
        step(4'b0000, 1'b1, 1'b1);
        repeat (5) step(4'b1111, 1'b1, 1'b0);

        // Lock under back-pressure, req0 joins mid-stall
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0110, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0111, 1'b0, 1'b0);
        step(4'b0111, 1'b1, 1'b0);
        // Next grant 2 (ptr=2), then wrap/skip: 3 then 0
        step(4'b0101, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 1'b0);
        step(4'b1001, 1'b1, 1'b0);

        // Violation: locked on req2, req2 drops
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0011, 1'b1, 1'b0);

        // Reset mid-lock: ptr=3 and locked on req3
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b1, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1010, 1'b0, 1'b1);
        step(4'b1010, 1'b1, 1'b0);

        // Randomized traffic, including stalls, withdrawals and resets
        for (int i = 0; i < 3000; i++) begin
            rv = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            if ($urandom_range(0, 3) == 0) rv = '0;
            rr = ($urandom_range(0, 9) < 6);
            rs = ($urandom_range(0, 99) == 0);
            step(rv, rr, rs);
        end

        step(4'b0000, 1'b0, 1'b0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
